// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// PwmPeriod is the nominal generator period in clk cycles.
package pwm_pkg;

    localparam int DataWidth = 10;
    localparam int PwmPeriod = 2 ** DataWidth;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Parameterised flop chain used to bring an asynchronous level into the clk domain.
// Every stage resets to 0.
module sync_ff #(
    parameter int Stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] chain_r;

    // shift the input through the synchronizer stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {Stages{1'b0}};
        end else begin
            chain_r <= {chain_r[Stages-2:0], d};
        end
    end

    assign q = chain_r[Stages-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and low time of an asynchronous PWM input and
// recovers the generator threshold; flags a stuck input through a period timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int DataWidth     = pwm_pkg::DataWidth,
    parameter int CountWidth    = DataWidth + 1,
    parameter int SyncStages    = 2,
    parameter int TimeoutCycles = 2 ** CountWidth - 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  pwmIn,
    output logic [CountWidth-1:0] period,
    output logic [CountWidth-1:0] highTime,
    output logic [CountWidth-1:0] lowTime,
    output logic [DataWidth-1:0]  treshold,
    output logic                  valid,
    output logic                  stuck
);

    localparam logic [CountWidth-1:0] CntMax     = {CountWidth{1'b1}};
    localparam logic [CountWidth-1:0] CntOne     = CountWidth'(1);
    localparam logic [CountWidth-1:0] CntZero    = {CountWidth{1'b0}};
    localparam logic [CountWidth-1:0] TimeoutVal = CountWidth'(TimeoutCycles);
    localparam logic [CountWidth-1:0] ThrLimit   = {{(CountWidth-DataWidth){1'b0}}, {DataWidth{1'b1}}};

    logic                  pwm_s;
    logic                  pwm_d_r;
    logic                  rise_s;
    state_t                state_r;
    logic [CountWidth-1:0] period_cnt_r;
    logic [CountWidth-1:0] high_cnt_r;
    logic                  pub_r;

    // low time clipped into the threshold range
    function automatic logic [DataWidth-1:0] sat_thr(input logic [CountWidth-1:0] v);
        if (v > ThrLimit) begin
            return {DataWidth{1'b1}};
        end else begin
            return v[DataWidth-1:0];
        end
    endfunction

    sync_ff #(
        .Stages(SyncStages)
    ) u_sync (
        .clk  (clk),
        .rst_n(rstN),
        .d    (pwmIn),
        .q    (pwm_s)
    );

    // one-cycle delayed copy of the synchronized input for edge detection
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pwm_d_r <= 1'b0;
        end else begin
            pwm_d_r <= pwm_s;
        end
    end

    assign rise_s = pwm_s & ~pwm_d_r;

    // measurement FSM: counters, stuck flag and the published measurement
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r      <= IDLE;
            period_cnt_r <= CntZero;
            high_cnt_r   <= CntZero;
            period       <= CntZero;
            highTime     <= CntZero;
            lowTime      <= CntZero;
            stuck        <= 1'b0;
            pub_r        <= 1'b0;
        end else begin
            pub_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r      <= MEASURE;
                        period_cnt_r <= CntOne;
                        high_cnt_r   <= CntOne;
                    end else begin
                        period_cnt_r <= CntZero;
                        high_cnt_r   <= CntZero;
                    end
                end
                MEASURE: begin
                    // an edge in the timeout cycle still counts as a normal period
                    if (rise_s) begin
                        period       <= period_cnt_r;
                        highTime     <= high_cnt_r;
                        lowTime      <= period_cnt_r - high_cnt_r;
                        pub_r        <= 1'b1;
                        period_cnt_r <= CntOne;
                        high_cnt_r   <= CntOne;
                    end else if (period_cnt_r == TimeoutVal) begin
                        period   <= TimeoutVal;
                        highTime <= pwm_s ? TimeoutVal : CntZero;
                        lowTime  <= pwm_s ? CntZero : TimeoutVal;
                        pub_r    <= 1'b1;
                        stuck    <= 1'b1;
                        state_r  <= STUCK;
                    end else begin
                        if (period_cnt_r != CntMax) begin
                            period_cnt_r <= period_cnt_r + CntOne;
                        end
                        if (pwm_s && (high_cnt_r != CntMax)) begin
                            high_cnt_r <= high_cnt_r + CntOne;
                        end
                    end
                end
                STUCK: begin
                    if (rise_s) begin
                        stuck        <= 1'b0;
                        period_cnt_r <= CntOne;
                        high_cnt_r   <= CntOne;
                        state_r      <= MEASURE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    period_cnt_r <= CntZero;
                    high_cnt_r   <= CntZero;
                    stuck        <= 1'b0;
                end
            endcase
        end
    end

    // threshold and valid follow the published measurement by one cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid    <= 1'b0;
            treshold <= {DataWidth{1'b0}};
        end else begin
            valid <= pub_r;
            if (pub_r) begin
                treshold <= sat_thr(lowTime);
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a scripted generator pushes expected
// measurements, an independent monitor pops and compares on every valid pulse.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int DW = 10;
    localparam int CW = 11;
    localparam int SS = 2;

    logic          clk   = 1'b0;
    logic          rstN  = 1'b0;
    logic          pwmIn = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] highTime;
    logic [CW-1:0] lowTime;
    logic [DW-1:0] treshold;
    logic          valid;
    logic          stuck;

    typedef struct {
        int per;
        int hi;
        int lo;
        int thr;
        int stk;
        bit lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc        = 0;
    int   last_rise  = 0;
    int   first_rise = 0;
    int   rises      = 0;
    int   epoch      = 0;
    int   mon_epoch  = 0;
    exp_t mon_e;

    pwm_capture #(
        .DataWidth (DW),
        .CountWidth(CW),
        .SyncStages(SS)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .pwmIn   (pwmIn),
        .period  (period),
        .highTime(highTime),
        .lowTime (lowTime),
        .treshold(treshold),
        .valid   (valid),
        .stuck   (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // hold the pin at lvl for n cycles, changing it just after a rising clk edge
    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (lvl && !pwmIn) begin
                last_rise = cyc;
                if (rises == 0) first_rise = cyc;
                rises++;
            end
            pwmIn = lvl;
        end
    endtask

    task automatic push(input int per, input int hi, input int lo, input int thr,
                        input int stk, input bit lat);
        exp_t e;
        e.per = per; e.hi = hi; e.lo = lo; e.thr = thr; e.stk = stk; e.lat = lat;
        sb.push_back(e);
    endtask

    // one generator period: low for t cycles, then high for the remainder
    task automatic pwm_period(input int t, input bit pub, input int per, input int hi);
        int lo;
        if (pub) begin
            lo = per - hi;
            push(per, hi, lo, (lo > 1023) ? 1023 : lo, 0, 1'b1);
        end
        drive(1'b0, t);
        drive(1'b1, PwmPeriod - t);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"},   int'(period),   0);
        chk({tag, "_high"},     int'(highTime), 0);
        chk({tag, "_low"},      int'(lowTime),  0);
        chk({tag, "_treshold"}, int'(treshold), 0);
        chk({tag, "_valid"},    int'(valid),    0);
        chk({tag, "_stuck"},    int'(stuck),    0);
    endtask

    // monitor: every valid pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                if (mon_epoch != epoch) begin
                    chk("first_valid_gap", cyc - first_rise, PwmPeriod + SS + 2);
                    mon_epoch = epoch;
                end
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("period",   int'(period),   mon_e.per);
                    chk("highTime", int'(highTime), mon_e.hi);
                    chk("lowTime",  int'(lowTime),  mon_e.lo);
                    chk("treshold", int'(treshold), mon_e.thr);
                    chk("stuck",    int'(stuck),    mon_e.stk);
                    if (mon_e.lat) chk("latency", cyc - last_rise, SS + 2);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rstN  = 1'b1;
        epoch = 1;
        rises = 0;

        // loopback at threshold 1000: first edge silent, then 1024/24/1000
        pwm_period(1000, 1'b0, 0, 0);
        repeat (3) pwm_period(1000, 1'b1, 1024, 24);
        // threshold 1023, then 512 (transition periods included)
        pwm_period(1023, 1'b1, 1047, 24);
        pwm_period(1023, 1'b1, 1024, 1);
        pwm_period(512, 1'b1, 513, 1);
        pwm_period(512, 1'b1, 1024, 512);
        wait_empty();

        // stuck high: threshold 0 keeps the pin high
        push(2047, 2047, 0, 0, 1, 1'b0);
        drive(1'b1, 3000);
        chk("stuck_high_level", int'(stuck), 1);
        pwm_period(300, 1'b0, 0, 0);
        chk("stuck_cleared", int'(stuck), 0);
        chk("held_period", int'(period), 2047);
        chk("held_high", int'(highTime), 2047);
        pwm_period(300, 1'b1, 1024, 724);
        wait_empty();

        // stuck low: pin forced low after a valid period
        push(2047, 0, 2047, 1023, 1, 1'b0);
        drive(1'b0, 3000);
        chk("stuck_low_level", int'(stuck), 1);
        pwm_period(400, 1'b0, 0, 0);
        pwm_period(400, 1'b1, 1024, 624);
        wait_empty();

        // asynchronous reset in the middle of a period
        drive(1'b0, 200);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #2;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rstN  = 1'b1;
        epoch = 2;
        rises = 0;
        pwm_period(1000, 1'b0, 0, 0);
        pwm_period(1000, 1'b1, 1024, 24);
        pwm_period(1000, 1'b1, 1024, 24);
        wait_empty();
        chk("final_stuck", int'(stuck), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator. Samples an asynchronous PWM input and measures period, high time and low time in clk cycles.
- Publishes the recovered threshold. A generator with 2**DataWidth-cycle period and threshold T produces low time == T.
- Used on the heater/fan feedback path and as a loopback checker for the generator.
- Detects a stuck-high or stuck-low input through a timeout.

Parameters:
- DataWidth, 10, threshold width; nominal PWM period is 2**DataWidth cycles.
- CountWidth, DataWidth+1, width of the period, high and low counters. Must be > DataWidth.
- SyncStages, 2, number of input synchronizer flops; minimum 2.
- TimeoutCycles, 2**CountWidth-1, period count at which no rising edge is declared a stuck input; must be < 2**CountWidth.

Ports:
- clk  in  1  system clock
- rstN  in  1  asynchronous active-low reset
- pwmIn  in  1  PWM input, asynchronous to clk
- period  out  CountWidth  last measured period, in cycles
- highTime  out  CountWidth  last measured high cycles
- lowTime  out  CountWidth  period - highTime
- treshold  out  DataWidth  recovered threshold: lowTime, saturated to 2**DataWidth-1
- valid  out  1  one-cycle pulse when the outputs update
- stuck  out  1  level; high while the input has timed out

Behaviour:
- Interface: one clock, clk; reset rstN is asynchronous, active-low. While rstN is low, every flop, every output and the FSM clear to 0 / IDLE. This also applies to reset mid-measurement; no partial result is published.
- Synchronizer: pwmIn passes through SyncStages flops to give pwmS. pwmD is pwmS delayed one cycle.
- Rising edge: a cycle with pwmS==1 and pwmD==0.
- FSM states:
  - IDLE: waits for the first rising edge; counters held at 0. On an edge, go to MEASURE and set periodCnt=1, highCnt=1. No valid pulse.
  - MEASURE, rising edge: publish period=periodCnt, highTime=highCnt, lowTime=periodCnt-highCnt. The next cycle, treshold and valid=1. In the edge cycle itself, set periodCnt=1, highCnt=1.
  - MEASURE, no edge: periodCnt+=1; highCnt+=pwmS.
  - MEASURE, periodCnt==TimeoutCycles with no edge: publish period=TimeoutCycles, highTime=TimeoutCycles if pwmS else 0, lowTime accordingly. Pulse valid, set stuck=1, go to STUCK.
  - STUCK: counters frozen; no further valid pulses. The next rising edge clears stuck, sets periodCnt=1, highCnt=1 and enters MEASURE without publishing, because the period is incomplete.
- Latency: outputs and valid are registered. They update 1 cycle after the edge-detect cycle, i.e. SyncStages+2 cycles after the pwmIn rising edge.
- Arithmetic:
  - Counters saturate at 2**CountWidth-1 and never wrap.
  - lowTime is never negative, since highCnt <= periodCnt by construction.
  - treshold = lowTime when lowTime < 2**DataWidth, else all-ones.
- Outputs hold their last published values between valid pulses.
- Simultaneous edge and timeout in the same cycle: the edge wins (normal publish, no stuck).
- A pulse narrower than one clk cycle may be missed. This is not an error.

Decomposition:
- Package pwm_pkg holds:
  - the FSM enum state_t {IDLE, MEASURE, STUCK};
  - the shared default DataWidth;
  - the helper constant PwmPeriod = 2**DataWidth, also used by the generator.
- One sub-module, sync_ff (parameterised flop chain, reset to 0), for the input synchronizer.
- Edge detect, counters and FSM stay in pwm_capture.

Test Plan:
- Generator loopback, treshold=1000, DataWidth=10 -> from the 2nd edge onward, every 1024 cycles: valid, period=1024, highTime=24, lowTime=1000, treshold=1000, stuck=0.
- First edge after reset -> no valid. The first valid arrives exactly 1024 cycles later, SyncStages+2 cycles after the 2nd pin edge.
- treshold=1023 -> highTime=1, lowTime=1023, treshold=1023. Then switch to 512 -> the next full period reports highTime=512, lowTime=512.
- treshold=0 (constant high) after one normal period -> valid pulse with period=2047, highTime=2047, lowTime=0, treshold=0, stuck=1.
  - No further valid pulses.
  - Restoring treshold=300 -> stuck clears on the first edge; the next valid reports lowTime=300.
- Input forced low after a valid period -> timeout reports highTime=0, lowTime=2047, treshold=1023, stuck=1.
- rstN pulsed low mid-period -> all outputs 0 immediately (asynchronously). After release, the first edge publishes nothing; the second publishes a correct period.
